// File: rtl/pf_pkg.sv
// Shared constants and state encoding for the playfield RAM engine.
package pf_pkg;

    localparam int PF_DATA_W = 8;
    localparam int PF_ADDR_W = 10;

    // Fill controller states; the debug output carries this encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } pf_state_e;

    // Plain constants for the state register.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/playfield_ram_engine_if.sv
// CPU access bus for the playfield RAM.
//
// Handshake: the CPU drives cpu_cs_l low (with cpu_we_l, cpu_addr and
// cpu_wdata) and holds the request unchanged until it sees cpu_ready high.
// The access is accepted on any rising edge where cpu_cs_l=0 and
// cpu_ready=1. A write takes effect on that edge. For a read, cpu_rdata is
// presented with cpu_rvalid=1 for exactly one cycle after the accepting
// edge. cpu_rdata keeps its last value while cpu_rvalid is low.
interface playfield_ram_engine_if
    import pf_pkg::*;
#(
    parameter int DATA_W = PF_DATA_W,
    parameter int ADDR_W = PF_ADDR_W
);
    logic              cpu_cs_l;
    logic              cpu_we_l;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    modport master (
        output cpu_cs_l, cpu_we_l, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rdata, cpu_rvalid
    );

    modport slave (
        input  cpu_cs_l, cpu_we_l, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rdata, cpu_rvalid
    );
endinterface

// File: rtl/pf_fill_fsm.sv
// Hardware clear controller: walks every address once, writing a latched value.
module pf_fill_fsm
    import pf_pkg::*;
#(
    parameter int DATA_W = PF_DATA_W,
    parameter int ADDR_W = PF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              idle,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic [1:0]        state_dbg
);
    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] value;

    // State, pointer and fill value; the pointer stops at the last address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            value <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_start) begin
                        state <= ST_FILL;
                        value <= clr_value;
                        ptr   <= '0;
                    end
                end
                ST_FILL: begin
                    if (ptr == {ADDR_W{1'b1}}) begin
                        state <= ST_DONE;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign fill_we   = (state == ST_FILL);
    assign fill_addr = ptr;
    assign fill_data = value;
    assign clr_busy  = (state == ST_FILL);
    assign clr_done  = (state == ST_DONE);
    assign idle      = (state == ST_IDLE);
    assign state_dbg = state;
endmodule

// File: rtl/playfield_ram_engine.sv
// Playfield tile RAM: one write port shared by CPU and clear engine,
// NUM_RD registered video read ports plus one registered CPU read port.
module playfield_ram_engine
    import pf_pkg::*;
#(
    parameter int DATA_W = PF_DATA_W,
    parameter int ADDR_W = PF_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    playfield_ram_engine_if.slave          cpu,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  vid_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]  vid_data,
    input  logic                           clr_start,
    input  logic [DATA_W-1:0]              clr_value,
    output logic                           clr_busy,
    output logic                           clr_done,
    output logic [1:0]                     fsm_state
);
    localparam int DEPTH = 1 << ADDR_W;

    // Not reset so it maps onto block RAM; software clears via clr_start.
    logic [DATA_W-1:0] mem [DEPTH];

    logic              idle;
    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              cpu_wr;
    logic              cpu_rd;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    pf_fill_fsm #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fill (
        .clk       (clk),
        .rst       (rst),
        .clr_start (clr_start),
        .clr_value (clr_value),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .idle      (idle),
        .fill_we   (fill_we),
        .fill_addr (fill_addr),
        .fill_data (fill_data),
        .state_dbg (fsm_state)
    );

    // The CPU is only served while the clear engine is idle.
    assign cpu.cpu_ready = idle;
    assign cpu_wr        = idle & ~cpu.cpu_cs_l & ~cpu.cpu_we_l;
    assign cpu_rd        = idle & ~cpu.cpu_cs_l &  cpu.cpu_we_l;

    // Single write port: fill and CPU never write in the same cycle.
    always_comb begin
        wr_en   = fill_we | cpu_wr;
        wr_addr = cpu.cpu_addr;
        wr_data = cpu.cpu_wdata;
        if (fill_we) begin
            wr_addr = fill_addr;
            wr_data = fill_data;
        end
    end

    // Memory write; reads below see the pre-edge contents (read-before-write).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Video read ports, one cycle latency, always active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_data <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                vid_data[i] <= mem[vid_addr[i]];
            end
        end
    end

    // CPU read port; data holds between accepted reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu.cpu_rvalid <= 1'b0;
            cpu.cpu_rdata  <= '0;
        end else begin
            cpu.cpu_rvalid <= cpu_rd;
            if (cpu_rd) begin
                cpu.cpu_rdata <= mem[cpu.cpu_addr];
            end
        end
    end
endmodule
